spi_pixel_writer: RTL and testbench

Downstream of the SPI register bank. Each Trigger pulse (emitted when the Blue register is written) captures the current Red/Green/Blue into a small pixel FIFO. The FIFO drains through a valid/ready write port into the SDRAM frame-buffer controller, at sequential pixel addresses inside the frame selected by ImgNum. sdram_write_load restarts the address sequence at pixel 0 of the frame currently selected by ImgNum.

---
 rtl/spi_pixel_writer_pkg.sv | 23 ++
 rtl/pixel_fifo.sv | 54 +++++
 rtl/spi_pixel_writer.sv | 165 ++++++++++++++++
 tb/tb_spi_pixel_writer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pixel_writer_pkg.sv
// Shared types and helpers for the SPI pixel writer.
// Define PIXEL_RGB888_EN to carry unpacked 24-bit {R,G,B} pixels instead of RGB565.
package spi_pixel_writer_pkg;

   typedef enum logic [1:0] {
      S_Idle,
      S_Load,
      S_Write
   } state_e;

`ifdef PIXEL_RGB888_EN
   localparam int unsigned PIX_W = 24;
`else
   localparam int unsigned PIX_W = 16;
`endif

   function automatic logic [15:0] pack_rgb565(input logic [7:0] r,
                                               input logic [7:0] g,
                                               input logic [7:0] b);
      return {r[7:3], g[7:2], b[7:3]};
   endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO; pointers carry one extra MSB to tell full from empty.
// A push while full is accepted only when a pop happens in the same cycle.
module pixel_fifo #(
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             wr_data,
   input  logic                     pop,
   output logic [W-1:0]             rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          do_push;
   logic          do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count   = wr_ptr_q - rd_ptr_q;
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q + PW'(do_push);
      rd_ptr_d = rd_ptr_q + PW'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/spi_pixel_writer.sv
// Captures SPI RGB pixels into a FIFO and streams them to the SDRAM frame buffer.
// PIXEL_RGB888_EN selects 24-bit {R,G,B} pixels instead of RGB565.
module spi_pixel_writer
   import spi_pixel_writer_pkg::*;
#(
   parameter int unsigned ADDR_W       = 24,
   parameter int unsigned FRAME_PIXELS = 384000,
   parameter int unsigned FRAME_SHIFT  = 19,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic              theClock,
   input  logic              theReset,
   input  logic [7:0]        Red,
   input  logic [7:0]        Green,
   input  logic [7:0]        Blue,
   input  logic [7:0]        ImgNum,
   input  logic              Trigger,
   input  logic              sdram_write_load,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [PIX_W-1:0]  wr_data,
   output logic              frame_done,
   output logic              overflow,
   output logic              busy
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   // Reset asserts asynchronously but is released in step with theClock.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge theClock or negedge theReset) begin
      if (!theReset) rst_sync_q <= '0;
      else           rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign rst_n = rst_sync_q[1];

   logic [PIX_W-1:0] pix_in;
   logic [PIX_W-1:0] fifo_head;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;

`ifdef PIXEL_RGB888_EN
   assign pix_in = {Red, Green, Blue};
`else
   assign pix_in = pack_rgb565(Red, Green, Blue);
`endif

   pixel_fifo #(
      .W     (PIX_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (theClock),
      .rst_n   (rst_n),
      .push    (Trigger),
      .wr_data (pix_in),
      .pop     (fifo_pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   state_e            state_q,      state_d;
   logic              wr_valid_q,   wr_valid_d;
   logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;
   logic [PIX_W-1:0]  wr_data_q,    wr_data_d;
   logic [ADDR_W-1:0] idx_q,        idx_d;
   logic [ADDR_W-1:0] base_q,       base_d;
   logic              pend_q,       pend_d;
   logic              frame_done_q, frame_done_d;
   logic              overflow_q,   overflow_d;
   logic [ADDR_W-1:0] load_base;

   // ImgNum bits that would land above ADDR_W fall off the cast.
   assign load_base = ADDR_W'({{ADDR_W{1'b0}}, ImgNum} << FRAME_SHIFT);

   always_comb begin
      state_d      = state_q;
      wr_valid_d   = wr_valid_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      idx_d        = idx_q;
      base_d       = base_q;
      pend_d       = pend_q | sdram_write_load;
      frame_done_d = 1'b0;
      fifo_pop     = 1'b0;

      unique case (state_q)
         S_Idle: begin
            if (pend_q) begin
               idx_d  = '0;
               base_d = load_base;
               pend_d = sdram_write_load;
            end
            if (!fifo_empty) state_d = S_Load;
         end
         S_Load: begin
            fifo_pop   = 1'b1;
            wr_data_d  = fifo_head;
            wr_addr_d  = base_q + idx_q;
            wr_valid_d = 1'b1;
            state_d    = S_Write;
         end
         S_Write: begin
            if (wr_ready) begin
               wr_valid_d = 1'b0;
               if (idx_q == ADDR_W'(FRAME_PIXELS - 1)) begin
                  idx_d        = '0;
                  frame_done_d = 1'b1;
               end else begin
                  idx_d = idx_q + ADDR_W'(1);
               end
               // A restart waits for acceptance so the pending request never changes.
               if (pend_q) begin
                  idx_d  = '0;
                  base_d = load_base;
                  pend_d = sdram_write_load;
               end
               state_d = fifo_empty ? S_Idle : S_Load;
            end
         end
         default: state_d = S_Idle;
      endcase

      overflow_d = overflow_q | (Trigger & fifo_full & ~fifo_pop);
   end

   always_ff @(posedge theClock or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_Idle;
         wr_valid_q   <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         idx_q        <= '0;
         base_q       <= '0;
         pend_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_valid_q   <= wr_valid_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         idx_q        <= idx_d;
         base_q       <= base_d;
         pend_q       <= pend_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
      end
   end

   assign wr_valid   = wr_valid_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;
   assign busy       = (fifo_count != '0) | wr_valid_q;

endmodule

// File: tb/tb_spi_pixel_writer.sv
// Self-checking bench for spi_pixel_writer: pixel table, scoreboard on the write port,
// and directed sequences for stall, overflow, frame wrap, deferred restart and reset.
`timescale 1ns/1ps
module tb_spi_pixel_writer;
   import spi_pixel_writer_pkg::*;

   localparam int unsigned ADDR_W = 24;
   localparam int unsigned FP     = 16;
   localparam int unsigned FS     = 19;
   localparam int unsigned DEPTH  = 8;

   logic              theClock = 1'b0;
   logic              theReset = 1'b1;
   logic [7:0]        Red = '0, Green = '0, Blue = '0, ImgNum = '0;
   logic              Trigger = 1'b0;
   logic              sdram_write_load = 1'b0;
   logic              wr_ready = 1'b0;
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [PIX_W-1:0]  wr_data;
   logic              frame_done;
   logic              overflow;
   logic              busy;

   always #5 theClock = ~theClock;

   spi_pixel_writer #(
      .ADDR_W       (ADDR_W),
      .FRAME_PIXELS (FP),
      .FRAME_SHIFT  (FS),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .theClock         (theClock),
      .theReset         (theReset),
      .Red              (Red),
      .Green            (Green),
      .Blue             (Blue),
      .ImgNum           (ImgNum),
      .Trigger          (Trigger),
      .sdram_write_load (sdram_write_load),
      .wr_valid         (wr_valid),
      .wr_ready         (wr_ready),
      .wr_addr          (wr_addr),
      .wr_data          (wr_data),
      .frame_done       (frame_done),
      .overflow         (overflow),
      .busy             (busy)
   );

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [PIX_W-1:0]  data;
   } exp_t;

   typedef struct {
      logic [7:0]  r, g, b;
      logic [15:0] c565;
   } vec_t;

   exp_t              sb[$];
   exp_t              mon_e;
   vec_t              tbl[6];
   int                n_vec = 0, n_err = 0, n_acc = 0, n_done = 0;
   logic [ADDR_W-1:0] last_acc_addr = '0, done_after_addr = '0;
   logic [ADDR_W-1:0] m_base = '0;
   int unsigned       m_idx = 0;

   function automatic logic [PIX_W-1:0] exp_pix(input logic [7:0] r, input logic [7:0] g,
                                                input logic [7:0] b, input logic [15:0] c565);
`ifdef PIXEL_RGB888_EN
      return {r, g, b};
`else
      return c565;
`endif
   endfunction

   function automatic logic [ADDR_W-1:0] nxt();
      logic [ADDR_W-1:0] a;
      a = m_base + ADDR_W'(m_idx);
      m_idx = (m_idx == FP - 1) ? 0 : m_idx + 1;
      return a;
   endfunction

   task automatic m_load(input logic [7:0] img);
      m_base = ADDR_W'({16'h0, img} << FS);
      m_idx  = 0;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge theClock);
      #1;
   endtask

   task automatic pulse_load(input logic [7:0] img);
      ImgNum = img;
      sdram_write_load = 1'b1;
      tick();
      sdram_write_load = 1'b0;
   endtask

   task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                             input logic [15:0] c565, input logic [ADDR_W-1:0] addr);
      sb.push_back('{addr, exp_pix(r, g, b, c565)});
      Red = r; Green = g; Blue = b; Trigger = 1'b1;
      tick();
      Trigger = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int unsigned n = 0;
      while (!wr_valid && n < 50) begin
         tick();
         n++;
      end
      check(name, 64'(wr_valid), 64'd1);
   endtask

   task automatic drain(input string name);
      int unsigned n = 0;
      while (sb.size() != 0 && n < 400) begin
         tick();
         n++;
      end
      check(name, 64'(sb.size()), 64'd0);
   endtask

   // Write-port monitor: every accepted write is popped from the scoreboard.
   always @(negedge theClock) begin
      if (theReset && wr_valid && wr_ready) begin
         n_acc++;
         last_acc_addr = wr_addr;
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL wr_port: unexpected write addr 0x%0h data 0x%0h, expected none",
                     wr_addr, wr_data);
         end else begin
            mon_e = sb.pop_front();
            if (wr_addr !== mon_e.addr || wr_data !== mon_e.data) begin
               n_err++;
               $display("FAIL wr_port: addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                        wr_addr, wr_data, mon_e.addr, mon_e.data);
            end
         end
      end
      if (theReset && frame_done) begin
         n_done++;
         done_after_addr = last_acc_addr;
      end
   end

   initial begin
      #1000000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      int unsigned lat;
      int          acc0, done0;
      logic [7:0]  r;

      tbl[0] = '{8'h00, 8'h00, 8'h00, 16'h0000};
      tbl[1] = '{8'hFF, 8'hFF, 8'hFF, 16'hFFFF};
      tbl[2] = '{8'h12, 8'h34, 8'h56, 16'h11AA};
      tbl[3] = '{8'hA5, 8'h5A, 8'hC3, 16'hA2D8};
      tbl[4] = '{8'h07, 8'h03, 8'h07, 16'h0000};
      tbl[5] = '{8'h08, 8'h04, 8'h08, 16'h0821};

      // Reset, with a Trigger that must be ignored.
      #3 theReset = 1'b0;
      tick();
      Trigger = 1'b1; Red = 8'hFF;
      tick();
      Trigger = 1'b0;
      check("rst_wr_valid", 64'(wr_valid), 64'd0);
      check("rst_outputs", {38'(wr_addr), 16'(wr_data), 7'd0, frame_done, overflow, busy}, 64'd0);
      theReset = 1'b1;
      repeat (4) tick();
      check("post_rst_idle", {wr_valid, frame_done, overflow, busy}, 64'd0);

      // First pixel to frame 2; latency from Trigger to wr_valid.
      pulse_load(8'd2);
      m_load(8'd2);
      tick();
      wr_ready = 1'b1;
      send_pixel(8'hFF, 8'h80, 8'h08, 16'hFC01, 24'h100000);
      m_idx = 1;
      lat = 0;
      do begin
         @(negedge theClock);
         lat++;
      end while (!wr_valid && lat < 20);
      check("first_latency", 64'(lat), 64'd3);
      drain("first_drain");

      // Pixel packing table.
      for (int i = 0; i < 6; i++) begin
         send_pixel(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].c565, nxt());
         tick();
         tick();
      end
      drain("table_drain");

      // Stalled write holds address and data.
      wr_ready = 1'b0;
      pulse_load(8'd2);
      m_load(8'd2);
      for (int i = 1; i <= 3; i++) begin
         r = 8'(i * 16);
         send_pixel(r, 8'h00, 8'h00, 16'(i << 12), nxt());
         tick();
      end
      wait_valid("stall_valid");
      for (int i = 0; i < 10; i++) begin
         @(negedge theClock);
         check("stall_hold", {23'd0, wr_valid, wr_addr, 16'(wr_data)},
               {23'd0, 1'b1, 24'h100000, 16'(exp_pix(8'h10, 8'h00, 8'h00, 16'h1000))});
      end
      tick();
      wr_ready = 1'b1;
      drain("stall_drain");
      @(negedge theClock);
      check("busy_after_drain", 64'(busy), 64'd0);

      // Overflow: one pixel in flight plus a full FIFO, then a dropped pixel.
      tick();
      wr_ready = 1'b0;
      pulse_load(8'd2);
      m_load(8'd2);
      tick();
      for (int i = 0; i < 9; i++) begin
         r = 8'((i + 1) * 8);
         sb.push_back('{nxt(), exp_pix(r, 8'h00, 8'h00, 16'((i + 1) << 11))});
         Red = r; Green = 8'h00; Blue = 8'h00; Trigger = 1'b1;
         tick();
      end
      Trigger = 1'b0;
      tick();
      tick();
      check("ovf_before_full_push", {overflow, busy}, 64'b01);
      Red = 8'hF8; Green = 8'hFC; Blue = 8'hF8; Trigger = 1'b1;
      tick();
      Trigger = 1'b0;
      @(negedge theClock);
      check("ovf_set", 64'(overflow), 64'd1);
      acc0 = n_acc;
      wr_ready = 1'b1;
      drain("ovf_drain");
      tick();
      check("ovf_write_count", 64'(n_acc - acc0), 64'd9);
      check("ovf_sticky", 64'(overflow), 64'd1);

      // Push into a full FIFO on the cycle it pops must be kept.
      wr_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         r = 8'((i + 11) * 8);
         sb.push_back('{nxt(), exp_pix(r, 8'h00, 8'h00, 16'((i + 11) << 11))});
         Red = r; Green = 8'h00; Blue = 8'h00; Trigger = 1'b1;
         tick();
      end
      Trigger = 1'b0;
      tick();
      tick();
      acc0 = n_acc;
      wr_ready = 1'b1;
      tick();
      wr_ready = 1'b0;
      send_pixel(8'h00, 8'h00, 8'hF8, 16'h001F, nxt());
      tick();
      wr_ready = 1'b1;
      drain("full_pushpop_drain");
      tick();
      check("full_pushpop_count", 64'(n_acc - acc0), 64'd10);

      // Frame wrap in frame 3.
      pulse_load(8'd3);
      m_load(8'd3);
      tick();
      done0 = n_done;
      for (int i = 0; i < FP - 2; i++) begin
         send_pixel(8'h00, 8'(i << 2), 8'h00, 16'(i << 5), nxt());
         tick();
         tick();
      end
      drain("wrap_pre_drain");
      check("wrap_no_early_done", 64'(n_done - done0), 64'd0);
      for (int i = 0; i < 3; i++) begin
         send_pixel(8'h00, 8'h00, 8'(i << 3), 16'(i), nxt());
         tick();
         tick();
      end
      drain("wrap_drain");
      tick();
      tick();
      check("wrap_done_pulses", 64'(n_done - done0), 64'd1);
      check("wrap_done_after", 64'(done_after_addr), 64'h18000F);

      // Restart request while a write is stalled.
      wr_ready = 1'b0;
      send_pixel(8'h40, 8'h40, 8'h40, 16'h4208, nxt());
      wait_valid("defer_valid");
      pulse_load(8'd1);
      tick();
      check("defer_hold", {39'd0, wr_valid, wr_addr}, {39'd0, 1'b1, 24'h180001});
      m_load(8'd1);
      send_pixel(8'h80, 8'h00, 8'hFF, 16'h801F, 24'h080000);
      m_idx = 1;
      tick();
      wr_ready = 1'b1;
      drain("defer_drain");

      // Reset in the middle of a stalled write.
      tick();
      wr_ready = 1'b0;
      send_pixel(8'hC0, 8'hC0, 8'hC0, 16'hC618, nxt());
      wait_valid("rst_mid_valid");
      #2 theReset = 1'b0;
      #1;
      check("rst_mid_outputs", {wr_valid, overflow, frame_done, busy}, 64'd0);
      sb.delete();
      repeat (3) @(posedge theClock);
      #1 theReset = 1'b1;
      repeat (4) tick();
      m_base = '0;
      m_idx  = 0;
      wr_ready = 1'b1;
      send_pixel(8'h18, 8'h24, 8'h30, 16'h1926, nxt());
      drain("after_rst_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
